// File: rtl/lcd_ctrl.sv
// Character LCD sequencer: runs the power-up init list, then issues byte-wide
// command/data requests with setup, enable-pulse, hold and execution-wait timing.
module lcd_ctrl #(
  parameter int unsigned T_PWR = 750000,
  parameter int unsigned T_SU  = 2,
  parameter int unsigned T_EN  = 12,
  parameter int unsigned T_H   = 1,
  parameter int unsigned T_CMD = 2000,
  parameter int unsigned T_CLR = 82000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_rs_i,
  input  logic [7:0]  req_data_i,
  output logic        busy_o,
  output logic        init_done_o,
  output logic [31:0] lcd_o
);

  localparam int unsigned T_M1  = (T_PWR > T_SU) ? T_PWR : T_SU;
  localparam int unsigned T_M2  = (T_M1 > T_EN) ? T_M1 : T_EN;
  localparam int unsigned T_M3  = (T_M2 > T_H) ? T_M2 : T_H;
  localparam int unsigned T_M4  = (T_M3 > T_CMD) ? T_M3 : T_CMD;
  localparam int unsigned T_MAX = (T_M4 > T_CLR) ? T_M4 : T_CLR;
  localparam int unsigned CW    = (T_MAX > 1) ? $clog2(T_MAX) : 1;

  typedef enum logic [2:0] {
    PWRUP,
    SETUP,
    ENHI,
    HOLD,
    WAIT,
    IDLE
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      idx_q, idx_d;
  logic            rs_q, rs_d;
  logic [7:0]      data_q, data_d;
  logic            done_q, done_d;
  logic            ready_q, ready_d;
  logic            busy_q, busy_d;
  logic            en_q, en_d;
  logic            on_q, on_d;
  logic            long_wait;

  // Fixed initialisation list: function set, display on, clear, entry mode
  function automatic logic [7:0] init_cmd(input logic [1:0] i);
    case (i)
      2'd0:    return 8'h38;
      2'd1:    return 8'h0C;
      2'd2:    return 8'h01;
      default: return 8'h06;
    endcase
  endfunction

  // Clear and home commands need the long execution wait
  assign long_wait = !rs_q && (data_q[7:2] == 6'd0) && (data_q != 8'd0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= PWRUP;
      cnt_q   <= CW'(T_PWR - 1);
      idx_q   <= 2'd0;
      rs_q    <= 1'b0;
      data_q  <= 8'd0;
      done_q  <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b1;
      en_q    <= 1'b0;
      on_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rs_q    <= rs_d;
      data_q  <= data_d;
      done_q  <= done_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      en_q    <= en_d;
      on_q    <= on_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rs_d    = rs_q;
    data_d  = data_q;
    done_d  = done_q;
    on_d    = 1'b1;

    case (state_q)
      PWRUP: begin
        if (cnt_q == '0) begin
          state_d = SETUP;
          cnt_d   = CW'(T_SU - 1);
          rs_d    = 1'b0;
          data_d  = init_cmd(idx_q);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      SETUP: begin
        if (cnt_q == '0) begin
          state_d = ENHI;
          cnt_d   = CW'(T_EN - 1);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ENHI: begin
        if (cnt_q == '0) begin
          state_d = HOLD;
          cnt_d   = CW'(T_H - 1);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      HOLD: begin
        if (cnt_q == '0) begin
          state_d = WAIT;
          cnt_d   = long_wait ? CW'(T_CLR - 1) : CW'(T_CMD - 1);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          if (done_q) begin
            state_d = IDLE;
          end else if (idx_q == 2'd3) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            idx_d   = idx_q + 2'd1;
            state_d = SETUP;
            cnt_d   = CW'(T_SU - 1);
            rs_d    = 1'b0;
            data_d  = init_cmd(idx_q + 2'd1);
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      IDLE: begin
        if (req_valid_i && ready_q) begin
          state_d = SETUP;
          cnt_d   = CW'(T_SU - 1);
          rs_d    = req_rs_i;
          data_d  = req_data_i;
        end
      end
      default: begin
        state_d = PWRUP;
        cnt_d   = CW'(T_PWR - 1);
      end
    endcase
  end

  // Handshake and status flags are registered alongside the state
  assign ready_d = (state_d == IDLE) && done_d;
  assign busy_d  = (state_d != IDLE);
  assign en_d    = (state_d == ENHI);

  assign req_ready_o = ready_q;
  assign busy_o      = busy_q;
  assign init_done_o = done_q;
  assign lcd_o       = {on_q, 20'd0, en_q, rs_q, 1'b0, data_q};

endmodule

// File: tb/tb_lcd_ctrl.sv
// Scoreboard bench for lcd_ctrl: expected transfers are queued at issue time and
// compared against observed EN pulses and ready-low windows.
module tb_lcd_ctrl;
  localparam int unsigned P_PWR = 10;
  localparam int unsigned P_SU  = 2;
  localparam int unsigned P_EN  = 3;
  localparam int unsigned P_H   = 1;
  localparam int unsigned P_CMD = 5;
  localparam int unsigned P_CLR = 20;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0;
  logic        ready;
  logic        rs = 1'b0;
  logic [7:0]  data = 8'd0;
  logic        busy;
  logic        done;
  logic [31:0] lcd;
  logic        live;

  typedef struct {
    logic       rs;
    logic [7:0] data;
    int         window;
  } xfer_t;

  xfer_t exp_q[$];
  int    checks = 0;
  int    failures = 0;

  lcd_ctrl #(
    .T_PWR(P_PWR), .T_SU(P_SU), .T_EN(P_EN), .T_H(P_H), .T_CMD(P_CMD), .T_CLR(P_CLR)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .req_valid_i(valid),
    .req_ready_o(ready),
    .req_rs_i(rs),
    .req_data_i(data),
    .busy_o(busy),
    .init_done_o(done),
    .lcd_o(lcd)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s: got event expected none", name);
  endtask

  // Reference: clear/home commands take the long wait, everything else the short one
  function automatic xfer_t mk(input logic r, input logic [7:0] d);
    xfer_t x;
    int    w;
    w = (!r && d >= 8'd1 && d <= 8'd3) ? int'(P_CLR) : int'(P_CMD);
    x.rs     = r;
    x.data   = d;
    x.window = int'(P_SU + P_EN + P_H) + w;
    return x;
  endfunction

  task automatic push_init();
    exp_q.push_back(mk(1'b0, 8'h38));
    exp_q.push_back(mk(1'b0, 8'h0C));
    exp_q.push_back(mk(1'b0, 8'h01));
    exp_q.push_back(mk(1'b0, 8'h06));
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) live <= 1'b0;
    else        live <= 1'b1;
  end

  // Monitor: pops one expected transfer per EN rising edge
  logic  prev_en = 1'b0;
  logic  prev_ready = 1'b0;
  logic  win_active = 1'b0;
  int    en_w = 0;
  int    win = 0;
  int    cur_window = 0;

  always @(negedge clk) begin
    xfer_t x;
    if (!rst_n || !live) begin
      prev_en    = 1'b0;
      prev_ready = 1'b0;
      win_active = 1'b0;
      en_w       = 0;
    end else begin
      check("lcd_fixed_bits", lcd & 32'hFFFF_F900, 32'h8000_0000);
      check("busy_vs_ready", {31'd0, busy ^ ready}, 32'd1);
      if (lcd[10] && !prev_en) begin
        if (exp_q.size() == 0) begin
          fail_now("unexpected_pulse");
        end else begin
          x = exp_q.pop_front();
          check("pulse_rs", {31'd0, lcd[9]}, {31'd0, x.rs});
          check("pulse_data", {24'd0, lcd[7:0]}, {24'd0, x.data});
          cur_window = x.window;
        end
        en_w = 1;
      end else if (lcd[10]) begin
        en_w++;
      end
      if (!lcd[10] && prev_en) check("en_width", en_w, P_EN);
      if (!ready && prev_ready) begin
        win_active = 1'b1;
        win        = 1;
      end else if (!ready && win_active) begin
        win++;
      end
      if (ready && !prev_ready && win_active) begin
        check("ready_low_window", win, cur_window);
        win_active = 1'b0;
      end
      prev_en    = lcd[10];
      prev_ready = ready;
    end
  end

  // Present a request and wait (bounded) for the accepting edge
  task automatic send(input logic r, input logic [7:0] d);
    int n;
    valid = 1'b1;
    rs    = r;
    data  = d;
    exp_q.push_back(mk(r, d));
    n = 0;
    @(negedge clk);
    while (!ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!ready) fail_now("accept_timeout");
    @(posedge clk);
    #1;
    check("ready_drops_on_accept", {31'd0, ready}, 32'd0);
  endtask

  task automatic release_init();
    int k;
    push_init();
    @(negedge clk);
    rst_n = 1'b1;
    k = 0;
    do begin
      @(posedge clk);
      #1;
      k++;
      if (k == 1) check("first_edge_lcd", lcd, 32'h8000_0000);
      if (!ready) check("init_done_early", {31'd0, done}, 32'd0);
    end while (!ready && k < 300);
    check("init_cycles", k, P_PWR + 3 * (P_SU + P_EN + P_H + P_CMD) + (P_SU + P_EN + P_H + P_CLR));
    check("init_done_set", {31'd0, done}, 32'd1);
  endtask

  initial begin
    logic [7:0] d;
    logic       r;
    int         n;

    repeat (2) @(negedge clk);
    check("reset_lcd", lcd, 32'h0);
    check("reset_ready", {31'd0, ready}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd1);
    check("reset_done", {31'd0, done}, 32'd0);

    // Early request during PWRUP must follow the last init command
    fork
      release_init();
      begin
        repeat (3) @(posedge clk);
        #1;
        send(1'b1, 8'h5A);
        valid = 1'b0;
      end
    join
    repeat (40) @(posedge clk);
    #1;

    // Exact bus words for a character write
    send(1'b1, 8'h41);
    valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check("data_write_word", lcd, (i < 2 || i == 5) ? 32'h8000_0241 : 32'h8000_0641);
      @(posedge clk);
      #1;
    end
    repeat (10) @(posedge clk);
    #1;

    // Clear vs normal command vs data byte 0x01, then a back-to-back stream
    send(1'b0, 8'h01);
    send(1'b0, 8'h80);
    send(1'b1, 8'h01);
    valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    send(1'b1, 8'h48);
    send(1'b1, 8'h49);
    send(1'b1, 8'h21);
    valid = 1'b0;

    // Randomised traffic biased toward the clear/home boundary
    for (int i = 0; i < 30; i++) begin
      r = 1'($urandom_range(0, 1));
      d = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 4)) : 8'($urandom);
      send(r, d);
      if ($urandom_range(0, 1) == 1) begin
        valid = 1'b0;
        repeat ($urandom_range(0, 5)) @(posedge clk);
        #1;
      end
    end
    valid = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);

    // Reset while EN is high
    send(1'b1, 8'h77);
    valid = 1'b0;
    n = 0;
    while (!lcd[10] && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("en_seen_before_reset", {31'd0, lcd[10]}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_lcd", lcd, 32'h0);
    check("async_reset_done", {31'd0, done}, 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    release_init();
    send(1'b1, 8'h33);
    valid = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("final_queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
